// File: rtl/apb_timer_regs_mc_if.sv
// APB bus bundle for the multi-channel timer register block.
// Master drives psel/penable/pwrite/paddr/pwdata; slave returns prdata/pready/pslverr.
interface apb_timer_regs_mc_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timer_regs_mc.sv
// Multi-channel APB timer register block with programmable wait states.
// Ports: pclk, preset_n (sync, active-low), apb slave bus, ovf/udf triggers
// in; load/updw/en/cks/tdr control fields and one irq per channel out.
module apb_timer_regs_mc #(
  parameter int CH          = 4,
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                pclk,
  input  logic                preset_n,
  apb_timer_regs_mc_if.slave  apb,
  input  logic [CH-1:0]       ovf_trig,
  input  logic [CH-1:0]       udf_trig,
  output logic [CH-1:0]       load,
  output logic [CH-1:0]       updw,
  output logic [CH-1:0]       en,
  output logic [2*CH-1:0]     cks,
  output logic [DW*CH-1:0]    tdr,
  output logic [CH-1:0]       irq
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] WAIT_INIT =
    3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
  localparam logic [31:0] NREG = 32'(4 * CH);

  state_t     state_q, state_n;
  logic [2:0] cnt_q, cnt_n;
  logic       enter_done;

  logic [CH-1:0][DW-1:0] tdr_q;
  logic [CH-1:0][1:0]    cks_q;
  logic [CH-1:0]         updw_q, en_q, load_q;
  logic [CH-1:0]         ovf_q, udf_q;
  logic [CH-1:0]         ovfie_q, udfie_q;

  logic          pready_q, pslverr_q;
  logic [DW-1:0] prdata_q;

  logic [31:0]   addr32, ch;
  logic [1:0]    off;
  logic          valid, commit;
  logic [DW-1:0] rd;
  logic [7:0]    wb;
  logic [CH-1:0] ws_tdr, ws_tcr, ws_tsr, ws_tier;

  assign addr32 = 32'(apb.paddr);
  assign ch     = {2'b00, addr32[31:2]};
  assign off    = addr32[1:0];
  assign valid  = addr32 < NREG;
  assign wb     = apb.pwdata[7:0];

  // pslverr_q is only ever set while in DONE, so it is the
  // error verdict for the transfer being completed
  assign commit = (state_q == S_DONE) & apb.psel & apb.penable
                & apb.pwrite & ~pslverr_q;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (apb.psel && !apb.penable) begin
          if (WAIT_CYCLES == 0) begin
            state_n = S_DONE;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!apb.psel)        state_n = S_IDLE;
        else if (cnt_q == '0) state_n = S_DONE;
        else                  cnt_n   = cnt_q - 3'd1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign enter_done = (state_n == S_DONE);

  always_comb begin
    rd = '0;
    for (int c = 0; c < CH; c++) begin
      if (ch == 32'(c)) begin
        unique case (off)
          2'd0: rd = tdr_q[c];
          2'd1: rd = DW'({updw_q[c], en_q[c], 2'b00, cks_q[c]});
          2'd2: rd = DW'({udf_q[c], ovf_q[c]});
          default: rd = DW'({udfie_q[c], ovfie_q[c]});
        endcase
      end
    end
  end

  always_comb begin
    ws_tdr  = '0;
    ws_tcr  = '0;
    ws_tsr  = '0;
    ws_tier = '0;
    for (int c = 0; c < CH; c++) begin
      if (commit && ch == 32'(c)) begin
        unique case (off)
          2'd0: ws_tdr[c]  = 1'b1;
          2'd1: ws_tcr[c]  = 1'b1;
          2'd2: ws_tsr[c]  = 1'b1;
          default: ws_tier[c] = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= enter_done;
      pslverr_q <= enter_done & ~valid;
      prdata_q  <= (enter_done && valid && !apb.pwrite) ? rd : '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      tdr_q   <= '0;
      cks_q   <= '0;
      updw_q  <= '0;
      en_q    <= '0;
      load_q  <= '0;
      ovf_q   <= '0;
      udf_q   <= '0;
      ovfie_q <= '0;
      udfie_q <= '0;
    end else begin
      load_q <= '0;
      for (int c = 0; c < CH; c++) begin
        if (ws_tdr[c]) tdr_q[c] <= apb.pwdata;
        if (ws_tcr[c]) begin
          load_q[c] <= wb[7];
          updw_q[c] <= wb[5];
          en_q[c]   <= wb[4];
          cks_q[c]  <= wb[1:0];
        end
        if (ws_tier[c]) begin
          ovfie_q[c] <= wb[0];
          udfie_q[c] <= wb[1];
        end
        // hardware set wins over a same-cycle write-0 clear
        ovf_q[c] <= ovf_trig[c]
                  | (ovf_q[c] & ~(ws_tsr[c] & ~wb[0]));
        udf_q[c] <= udf_trig[c]
                  | (udf_q[c] & ~(ws_tsr[c] & ~wb[1]));
      end
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

  assign load = load_q;
  assign updw = updw_q;
  assign en   = en_q;
  assign cks  = cks_q;
  assign tdr  = tdr_q;
  assign irq  = (ovf_q & ovfie_q) | (udf_q & udfie_q);
endmodule

// File: tb/tb_apb_timer_regs_mc.sv
// Self-checking bench for apb_timer_regs_mc against a register-map model.
// Drives and samples on pclk negedges; second instance has no wait states.
module tb_apb_timer_regs_mc;
  localparam int CH = 4;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int WC = 2;
  localparam int OW = 5 * CH + DW * CH;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  apb_timer_regs_mc_if #(.AW(AW), .DW(DW)) bus ();
  apb_timer_regs_mc_if #(.AW(AW), .DW(DW)) bus0 ();

  logic [CH-1:0]    ovf_trig, udf_trig, load, updw, en, irq;
  logic [2*CH-1:0]  cks;
  logic [DW*CH-1:0] tdr;
  logic [CH-1:0]    trig0, load0, updw0, en0, irq0;
  logic [2*CH-1:0]  cks0;
  logic [DW*CH-1:0] tdr0;
  logic [OW-1:0]    outs;

  assign outs  = {irq, en, updw, cks, tdr};
  assign trig0 = '0;

  apb_timer_regs_mc #(
    .CH(CH), .DW(DW), .AW(AW), .WAIT_CYCLES(WC)
  ) u_dut (
    .pclk(pclk), .preset_n(preset_n), .apb(bus),
    .ovf_trig(ovf_trig), .udf_trig(udf_trig),
    .load(load), .updw(updw), .en(en),
    .cks(cks), .tdr(tdr), .irq(irq)
  );

  apb_timer_regs_mc #(
    .CH(CH), .DW(DW), .AW(AW), .WAIT_CYCLES(0)
  ) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .apb(bus0),
    .ovf_trig(trig0), .udf_trig(trig0),
    .load(load0), .updw(updw0), .en(en0),
    .cks(cks0), .tdr(tdr0), .irq(irq0)
  );

  int total = 0;
  int bad = 0;

  logic [DW-1:0] m_tdr [CH];
  logic [7:0]    m_tcr [CH];
  logic [7:0]    m_tsr [CH];
  logic [7:0]    m_tier[CH];

  function automatic void m_reset();
    for (int c = 0; c < CH; c++) begin
      m_tdr[c] = '0;
      m_tcr[c] = '0;
      m_tsr[c] = '0;
      m_tier[c] = '0;
    end
  endfunction

  function automatic logic [DW-1:0] m_read(int a);
    if (a >= 4 * CH) return '0;
    case (a % 4)
      0: return m_tdr[a / 4];
      1: return DW'(m_tcr[a / 4]);
      2: return DW'(m_tsr[a / 4]);
      default: return DW'(m_tier[a / 4]);
    endcase
  endfunction

  function automatic void m_write(int a, logic [DW-1:0] d);
    if (a >= 4 * CH) return;
    case (a % 4)
      0: m_tdr[a / 4] = d;
      1: m_tcr[a / 4] = d[7:0] & 8'h33;
      2: m_tsr[a / 4] = m_tsr[a / 4] & d[7:0];
      default: m_tier[a / 4] = d[7:0] & 8'h03;
    endcase
  endfunction

  function automatic void m_trig(logic [CH-1:0] o, logic [CH-1:0] u);
    for (int c = 0; c < CH; c++)
      m_tsr[c] = m_tsr[c] | {6'b0, u[c], o[c]};
  endfunction

  function automatic logic [OW-1:0] exp_outs();
    logic [CH-1:0]    i_, e_, u_;
    logic [2*CH-1:0]  k_;
    logic [DW*CH-1:0] t_;
    for (int c = 0; c < CH; c++) begin
      i_[c] = |(m_tsr[c] & m_tier[c]);
      e_[c] = m_tcr[c][4];
      u_[c] = m_tcr[c][5];
      k_[2*c +: 2] = m_tcr[c][1:0];
      t_[DW*c +: DW] = m_tdr[c];
    end
    return {i_, e_, u_, k_, t_};
  endfunction

  task automatic idle();
    @(negedge pclk);
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    ovf_trig = '0;
    udf_trig = '0;
  endtask

  task automatic pulse(input logic [CH-1:0] o, input logic [CH-1:0] u);
    @(negedge pclk);
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    ovf_trig = o;
    udf_trig = u;
    @(negedge pclk);
    ovf_trig = '0;
    udf_trig = '0;
    m_trig(o, u);
  endtask

  // returns at the negedge inside the DONE cycle; ot/ut are applied then
  task automatic xfer(input logic wr, input int a, input logic [DW-1:0] d,
                      input logic [CH-1:0] ot, input logic [CH-1:0] ut,
                      output logic [DW-1:0] r, output logic e,
                      output int n);
    @(negedge pclk);
    ovf_trig = '0;
    udf_trig = '0;
    bus.psel = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite = wr;
    bus.paddr = AW'(a);
    bus.pwdata = d;
    @(negedge pclk);
    bus.penable = 1'b1;
    n = 0;
    r = '0;
    e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.pready === 1'b1) begin
        n = i;
        r = bus.prdata;
        e = bus.pslverr;
        break;
      end
      @(negedge pclk);
    end
    ovf_trig = ot;
    udf_trig = ut;
  endtask

  task automatic xfer0(input logic wr, input int a, input logic [DW-1:0] d,
                       output logic [DW-1:0] r, output logic e,
                       output int n);
    @(negedge pclk);
    bus0.psel = 1'b1;
    bus0.penable = 1'b0;
    bus0.pwrite = wr;
    bus0.paddr = AW'(a);
    bus0.pwdata = d;
    @(negedge pclk);
    bus0.penable = 1'b1;
    n = 0;
    r = '0;
    e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (bus0.pready === 1'b1) begin
        n = i;
        r = bus0.prdata;
        e = bus0.pslverr;
        break;
      end
      @(negedge pclk);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] r;
    logic e;
    int n;
    preset_n = 1'b0;
    repeat (3) @(negedge pclk);
    total++;
    if ({outs, load, bus.pready, bus.pslverr, bus.prdata} !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%h want=0", outs);
    end
    preset_n = 1'b1;
    m_reset();
    for (int a = 0; a < 4 * CH; a++) begin
      xfer(1'b0, a, '0, '0, '0, r, e, n);
      total++;
      if (r !== m_read(a) || e !== 1'b0 || n != WC + 1) begin
        bad++;
        $display("FAIL reset_read a=%0d got r=%h e=%b n=%0d want r=%h e=0 n=%0d",
                 a, r, e, n, m_read(a), WC + 1);
      end
    end
    idle();
    total++;
    if ({outs, load} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got=%h want=0", {outs, load});
    end
  endtask

  task automatic test_ch2_ctrl();
    logic [DW-1:0] r;
    logic e;
    int n;
    xfer(1'b1, 8, 8'hA5, '0, '0, r, e, n);
    m_write(8, 8'hA5);
    xfer(1'b1, 9, 8'hB3, '0, '0, r, e, n);
    m_write(9, 8'hB3);
    idle();
    total++;
    if (load !== 4'b0100) begin
      bad++;
      $display("FAIL load_pulse got=%b want=0100", load);
    end
    total++;
    if (tdr[23:16] !== 8'hA5 || updw[2] !== 1'b1 || en[2] !== 1'b1
        || cks[5:4] !== 2'b11 || outs !== exp_outs()) begin
      bad++;
      $display("FAIL ch2_fields got=%h want=%h", outs, exp_outs());
    end
    idle();
    total++;
    if (load !== '0) begin
      bad++;
      $display("FAIL load_clear got=%b want=0000", load);
    end
    xfer(1'b0, 9, '0, '0, '0, r, e, n);
    total++;
    if (r !== 8'h33 || r !== m_read(9)) begin
      bad++;
      $display("FAIL tcr_readback got=%h want=33", r);
    end
  endtask

  task automatic test_ovf_clear();
    logic [DW-1:0] r;
    logic e;
    int n;
    xfer(1'b1, 7, 8'h01, '0, '0, r, e, n);
    m_write(7, 8'h01);
    pulse(4'b0010, 4'b0000);
    total++;
    if (irq[1] !== 1'b1 || outs !== exp_outs()) begin
      bad++;
      $display("FAIL ovf_irq got=%h want=%h", outs, exp_outs());
    end
    xfer(1'b0, 6, '0, '0, '0, r, e, n);
    total++;
    if (r !== 8'h01) begin
      bad++;
      $display("FAIL ovf_tsr got=%h want=01", r);
    end
    xfer(1'b1, 6, 8'hFE, '0, '0, r, e, n);
    m_write(6, 8'hFE);
    idle();
    total++;
    if (irq[1] !== 1'b0 || outs !== exp_outs()) begin
      bad++;
      $display("FAIL ovf_clear got=%h want=%h", outs, exp_outs());
    end
    pulse(4'b0010, 4'b0000);
    xfer(1'b1, 6, 8'hFF, '0, '0, r, e, n);
    m_write(6, 8'hFF);
    xfer(1'b0, 6, '0, '0, '0, r, e, n);
    total++;
    if (r !== 8'h01 || irq[1] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_keep got=%h irq=%b want=01 irq=1", r, irq[1]);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] r;
    logic e;
    int n;
    xfer(1'b1, 3, 8'h03, '0, '0, r, e, n);
    m_write(3, 8'h03);
    pulse(4'b0001, 4'b0000);
    xfer(1'b1, 2, 8'h00, 4'b0000, 4'b0001, r, e, n);
    m_write(2, 8'h00);
    m_trig(4'b0000, 4'b0001);
    idle();
    total++;
    if (outs !== exp_outs()) begin
      bad++;
      $display("FAIL simul_outs got=%h want=%h", outs, exp_outs());
    end
    xfer(1'b0, 2, '0, '0, '0, r, e, n);
    total++;
    if (r !== 8'h02 || r !== m_read(2)) begin
      bad++;
      $display("FAIL simul_tsr got=%h want=02", r);
    end
  endtask

  task automatic test_error();
    logic [DW-1:0] r;
    logic e;
    int n;
    xfer(1'b1, 16, 8'h5A, '0, '0, r, e, n);
    total++;
    if (e !== 1'b1 || r !== '0 || n != WC + 1) begin
      bad++;
      $display("FAIL err_write got e=%b r=%h n=%0d want e=1 r=0 n=%0d",
               e, r, n, WC + 1);
    end
    xfer(1'b0, 16, '0, '0, '0, r, e, n);
    total++;
    if (e !== 1'b1 || r !== '0) begin
      bad++;
      $display("FAIL err_read got e=%b r=%h want e=1 r=0", e, r);
    end
    xfer(1'b1, 255, 8'hFF, '0, '0, r, e, n);
    idle();
    total++;
    if (outs !== exp_outs() || load !== '0) begin
      bad++;
      $display("FAIL err_nochange got=%h want=%h", outs, exp_outs());
    end
    xfer(1'b0, 0, '0, '0, '0, r, e, n);
    total++;
    if (e !== 1'b0 || r !== m_read(0)) begin
      bad++;
      $display("FAIL err_recover got e=%b r=%h want e=0 r=%h",
               e, r, m_read(0));
    end
  endtask

  task automatic test_random_regs();
    logic [DW-1:0] r, d;
    logic e, wr, bad_a;
    int n, a;
    for (int k = 0; k < 60; k++) begin
      bad_a = ($urandom_range(0, 9) == 0);
      a = bad_a ? int'($urandom_range(4 * CH, 255))
                : int'($urandom_range(0, 4 * CH - 1));
      wr = 1'($urandom);
      d = DW'($urandom);
      xfer(wr, a, d, '0, '0, r, e, n);
      total++;
      if (e !== bad_a || n != WC + 1 || load !== '0
          || outs !== exp_outs()
          || (!wr && r !== m_read(a)) || (wr && r !== '0)) begin
        bad++;
        $display("FAIL rand_reg k=%0d a=%0d wr=%b got r=%h e=%b n=%0d o=%h want r=%h e=%b o=%h",
                 k, a, wr, r, e, n, outs, wr ? '0 : m_read(a), bad_a,
                 exp_outs());
      end
      if (wr) m_write(a, d);
      if (wr && !bad_a && a % 4 == 1) begin
        idle();
        total++;
        if (load !== (CH'(d[7]) << (a / 4))) begin
          bad++;
          $display("FAIL rand_load got=%b want=%b", load,
                   CH'(d[7]) << (a / 4));
        end
      end
    end
  endtask

  task automatic test_random_trig();
    logic [DW-1:0] r;
    logic [CH-1:0] o, u;
    logic e;
    int n, c;
    for (int k = 0; k < 30; k++) begin
      o = CH'($urandom);
      u = CH'($urandom);
      if (k % 4 == 0) begin
        c = int'($urandom_range(0, CH - 1));
        r = DW'($urandom);
        xfer(1'b1, 4 * c + 3, r, '0, '0, r, e, n);
        m_write(4 * c + 3, bus.pwdata);
      end
      pulse(o, u);
      total++;
      if (outs !== exp_outs()) begin
        bad++;
        $display("FAIL rand_trig k=%0d got=%h want=%h", k, outs, exp_outs());
      end
      if (k % 3 == 0) begin
        c = int'($urandom_range(0, CH - 1));
        r = DW'($urandom);
        xfer(1'b1, 4 * c + 2, r, '0, '0, r, e, n);
        m_write(4 * c + 2, bus.pwdata);
      end
      c = int'($urandom_range(0, CH - 1));
      xfer(1'b0, 4 * c + 2, '0, '0, '0, r, e, n);
      total++;
      if (r !== m_read(4 * c + 2)) begin
        bad++;
        $display("FAIL rand_tsr k=%0d ch=%0d got=%h want=%h",
                 k, c, r, m_read(4 * c + 2));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] r;
    logic [DW-1:0] v[CH];
    logic e;
    int n;
    for (int c = 0; c < CH; c++) begin
      v[c] = DW'($urandom);
      xfer(1'b1, 4 * c, v[c], '0, '0, r, e, n);
      m_write(4 * c, v[c]);
    end
    for (int c = 0; c < CH; c++) begin
      xfer(1'b0, 4 * c, '0, '0, '0, r, e, n);
      total++;
      if (r !== v[c] || n != WC + 1) begin
        bad++;
        $display("FAIL b2b ch=%0d got r=%h n=%0d want r=%h n=%0d",
                 c, r, n, v[c], WC + 1);
      end
    end
  endtask

  task automatic test_psel_drop();
    logic [DW-1:0] r;
    logic e, seen;
    int n;
    @(negedge pclk);
    bus.psel = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite = 1'b1;
    bus.paddr = AW'(12);
    bus.pwdata = ~m_tdr[3];
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      if (bus.pready !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL drop_pready got=1 want=0");
    end
    xfer(1'b0, 12, '0, '0, '0, r, e, n);
    total++;
    if (r !== m_tdr[3] || n != WC + 1) begin
      bad++;
      $display("FAIL drop_nowrite got r=%h n=%0d want r=%h n=%0d",
               r, n, m_tdr[3], WC + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] r;
    logic e;
    int n;
    @(negedge pclk);
    bus.psel = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite = 1'b1;
    bus.paddr = AW'(5);
    bus.pwdata = 8'h93;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    preset_n = 1'b0;
    @(negedge pclk);
    total++;
    if ({outs, load, bus.pready, bus.pslverr, bus.prdata} !== '0) begin
      bad++;
      $display("FAIL midreset_outs got=%h load=%b rdy=%b want 0",
               outs, load, bus.pready);
    end
    preset_n = 1'b1;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    m_reset();
    for (int a = 0; a < 4 * CH; a++) begin
      xfer(1'b0, a, '0, '0, '0, r, e, n);
      total++;
      if (r !== m_read(a) || e !== 1'b0) begin
        bad++;
        $display("FAIL midreset_read a=%0d got=%h want=%h", a, r, m_read(a));
      end
    end
    idle();
    total++;
    if ({outs, load} !== '0) begin
      bad++;
      $display("FAIL midreset_ctrl got=%h want=0", {outs, load});
    end
  endtask

  task automatic test_wait0();
    logic [DW-1:0] r;
    logic e;
    int n;
    xfer0(1'b1, 0, 8'h3C, r, e, n);
    total++;
    if (n != 1 || e !== 1'b0) begin
      bad++;
      $display("FAIL wait0_write got n=%0d e=%b want n=1 e=0", n, e);
    end
    xfer0(1'b0, 0, '0, r, e, n);
    total++;
    if (n != 1 || r !== 8'h3C || tdr0[7:0] !== 8'h3C) begin
      bad++;
      $display("FAIL wait0_read got n=%0d r=%h want n=1 r=3c", n, r);
    end
    @(negedge pclk);
    bus0.psel = 1'b0;
    bus0.penable = 1'b0;
  endtask

  initial begin
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite = 1'b0;
    bus.paddr = '0;
    bus.pwdata = '0;
    bus0.psel = 1'b0;
    bus0.penable = 1'b0;
    bus0.pwrite = 1'b0;
    bus0.paddr = '0;
    bus0.pwdata = '0;
    ovf_trig = '0;
    udf_trig = '0;
    m_reset();
    test_reset();
    test_ch2_ctrl();
    test_ovf_clear();
    test_simultaneous();
    test_error();
    test_random_regs();
    test_random_trig();
    test_back_to_back();
    test_psel_drop();
    test_wait0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
